alu_cmd_sequencer: RTL and testbench

- Initiator side of the 8-bit ALU interface.
- Accepts {opcode, a, b} commands over a valid/ready stream and buffers them in a small FIFO.
- Drives the ALU's init/opco/a/b inputs one command at a time, waits a programmable settle window, then captures the ALU's 16-bit out and five flags.
- Returns the captured result over a valid/ready response stream. Sits between the control path and the combinational ALU.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_fifo.sv | 71 +++++++
 rtl/alu_cmd_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared widths, flag bit positions, state encoding and command record for the
// ALU command sequencer and its command FIFO.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int OPCO_W = 4;
    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
    localparam int FLAG_W = 5;

    // Bit positions inside rsp_flags.
    localparam int FLG_CARRY = 0;
    localparam int FLG_LOG   = 1;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_SHIFT = 3;
    localparam int FLG_DONE  = 4;

    localparam int CMD_W = OPCO_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESPOND
    } seq_state_t;

    // One buffered command as it sits in the FIFO.
    typedef struct packed {
        logic [OPCO_W-1:0] opco;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// -----------------------------------------------------------------------------
// alu_seq_fifo
// Synchronous FIFO with first-word fall-through read (rdata always shows the
// head entry). Push while full and pop while empty are ignored.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write request and data
//   pop           remove head entry
//   rdata         head entry (valid when !empty)
//   full, empty   occupancy flags
//   count         current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module alu_seq_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // DEPTH is a power of two, so pointers wrap by plain overflow.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers guarantee stale entries are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Initiator for the combinational 8-bit ALU. Commands {opco, a, b} are buffered
// in a FIFO, driven onto the ALU one at a time, held for SETTLE_CYCLES, then the
// ALU result and flags are captured and returned on a valid/ready stream.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_*       command stream in
//   alu_init/alu_opco/alu_a/alu_b   registered ALU inputs
//   alu_out, alu_*flag              ALU result and flags
//   rsp_valid/rsp_ready/rsp_*       response stream out
//   busy, fifo_count                status
// Optional: define ALU_CMD_SEQUENCER_STATS_EN to add saturating stat_ops and
// stat_zero response counters.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [OPCO_W-1:0]             cmd_opco,
    input  logic [DATA_W-1:0]             cmd_a,
    input  logic [DATA_W-1:0]             cmd_b,
    output logic                          alu_init,
    output logic [OPCO_W-1:0]             alu_opco,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    input  logic [RES_W-1:0]              alu_out,
    input  logic                          alu_carryflag,
    input  logic                          alu_logflag,
    input  logic                          alu_zeroflag,
    input  logic                          alu_shiftflag,
    input  logic                          alu_doneflag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [OPCO_W-1:0]             rsp_opco,
    output logic [RES_W-1:0]              rsp_data,
    output logic [FLAG_W-1:0]             rsp_flags,
    output logic                          busy,
`ifdef ALU_CMD_SEQUENCER_STATS_EN
    output logic [15:0]                   stat_ops,
    output logic [15:0]                   stat_zero,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Wide enough to hold SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic              alu_init_q, alu_init_d;
    logic [OPCO_W-1:0] alu_opco_q, alu_opco_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [OPCO_W-1:0] rsp_opco_q, rsp_opco_d;
    logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

    alu_cmd_t head;
    logic     fifo_full, fifo_empty;
    logic     push, pop, capture, rsp_hs;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign rsp_hs    = rsp_valid_q && rsp_ready;

    alu_seq_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({cmd_opco, cmd_a, cmd_b}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            alu_init_q   <= 1'b0;
            alu_opco_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_opco_q   <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            alu_init_q   <= alu_init_d;
            alu_opco_q   <= alu_opco_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_opco_q   <= rsp_opco_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d      = SETTLE;
                    settle_cnt_d = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = RESPOND;
                end else begin
                    settle_cnt_d = settle_cnt_q - CNT_W'(1);
                end
            end
            RESPOND: begin
                // Return to IDLE only; the next pop happens one edge later.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        pop         = (state_q == IDLE) && !fifo_empty;
        capture     = (state_q == SETTLE) && (settle_cnt_q == '0);
        alu_init_d  = alu_init_q | pop;   // sticky until reset
        alu_opco_d  = alu_opco_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_opco_d  = rsp_opco_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;

        if (pop) begin
            alu_opco_d = head.opco;
            alu_a_d    = head.a;
            alu_b_d    = head.b;
        end

        if (capture) begin
            rsp_valid_d            = 1'b1;
            rsp_opco_d             = alu_opco_q;
            rsp_data_d             = alu_out;
            rsp_flags_d[FLG_CARRY] = alu_carryflag;
            rsp_flags_d[FLG_LOG]   = alu_logflag;
            rsp_flags_d[FLG_ZERO]  = alu_zeroflag;
            rsp_flags_d[FLG_SHIFT] = alu_shiftflag;
            rsp_flags_d[FLG_DONE]  = alu_doneflag;
        end

        if (rsp_hs) begin
            rsp_valid_d = 1'b0;
        end
    end

    assign alu_init  = alu_init_q;
    assign alu_opco  = alu_opco_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_opco  = rsp_opco_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef ALU_CMD_SEQUENCER_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_zero_q, stat_zero_d;

    always_comb begin
        stat_ops_d  = stat_ops_q;
        stat_zero_d = stat_zero_q;
        if (rsp_hs) begin
            if (stat_ops_q != 16'hFFFF) begin
                stat_ops_d = stat_ops_q + 16'd1;
            end
            if (rsp_flags_q[FLG_ZERO] && (stat_zero_q != 16'hFFFF)) begin
                stat_zero_d = stat_zero_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q  <= '0;
            stat_zero_q <= '0;
        end else begin
            stat_ops_q  <= stat_ops_d;
            stat_zero_q <= stat_zero_d;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_zero = stat_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Bench for alu_cmd_sequencer: one instance with default parameters and one
// with SETTLE_CYCLES=1, each driving a stub ALU (out={a,b}, zero=(a==0),
// carry=opco[0], other flags 0). Expected responses come from a queue of
// accepted commands.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    typedef struct packed {
        logic [3:0] opco;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef struct packed {
        logic [3:0]  opco;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_data;
        logic [4:0]  exp_flags;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- instance 0: defaults ----------------
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_opco;
    logic [7:0]  cmd_a, cmd_b;
    logic        alu_init;
    logic [3:0]  alu_opco;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_out;
    logic        cf, lf, zf, sf, df;
    logic        rsp_valid, rsp_ready;
    logic [3:0]  rsp_opco;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        busy;
    logic [2:0]  fifo_count;
`ifdef ALU_CMD_SEQUENCER_STATS_EN
    logic [15:0] stat_ops, stat_zero, stat_ops_1, stat_zero_1;
`endif

    assign alu_out = {alu_a, alu_b};
    assign zf      = (alu_a == 8'd0);
    assign cf      = alu_opco[0];
    assign lf      = 1'b0;
    assign sf      = 1'b0;
    assign df      = 1'b0;

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opco(cmd_opco), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_init(alu_init), .alu_opco(alu_opco), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carryflag(cf), .alu_logflag(lf),
        .alu_zeroflag(zf), .alu_shiftflag(sf), .alu_doneflag(df),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_opco(rsp_opco), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .busy(busy),
`ifdef ALU_CMD_SEQUENCER_STATS_EN
        .stat_ops(stat_ops), .stat_zero(stat_zero),
`endif
        .fifo_count(fifo_count)
    );

    // ---------------- instance 1: SETTLE_CYCLES=1 ----------------
    logic        cmd_valid_1, cmd_ready_1;
    logic [3:0]  cmd_opco_1;
    logic [7:0]  cmd_a_1, cmd_b_1;
    logic        alu_init_1;
    logic [3:0]  alu_opco_1;
    logic [7:0]  alu_a_1, alu_b_1;
    logic        rsp_valid_1, rsp_ready_1;
    logic [3:0]  rsp_opco_1;
    logic [15:0] rsp_data_1;
    logic [4:0]  rsp_flags_1;
    logic        busy_1;
    logic [2:0]  fifo_count_1;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut_1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
        .cmd_opco(cmd_opco_1), .cmd_a(cmd_a_1), .cmd_b(cmd_b_1),
        .alu_init(alu_init_1), .alu_opco(alu_opco_1), .alu_a(alu_a_1), .alu_b(alu_b_1),
        .alu_out({alu_a_1, alu_b_1}), .alu_carryflag(alu_opco_1[0]), .alu_logflag(1'b0),
        .alu_zeroflag(alu_a_1 == 8'd0), .alu_shiftflag(1'b0), .alu_doneflag(1'b0),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_opco(rsp_opco_1), .rsp_data(rsp_data_1), .rsp_flags(rsp_flags_1),
        .busy(busy_1),
`ifdef ALU_CMD_SEQUENCER_STATS_EN
        .stat_ops(stat_ops_1), .stat_zero(stat_zero_1),
`endif
        .fifo_count(fifo_count_1)
    );

    // ---------------- model / bookkeeping ----------------
    int   checks   = 0;
    int   failures = 0;
    cmd_t exp_q[$];
    cmd_t exp1_q[$];
    int   stat_ops_m  = 0;
    int   stat_zero_m = 0;

    function automatic logic [4:0] exp_flags(input cmd_t c);
        return {1'b0, 1'b0, (c.a == 8'd0), 1'b0, c.opco[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_opco  = op;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        if (!cmd_ready) begin
            fail_timeout("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back('{opco: op, a: a, b: b});
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input cmd_t c);
        check({tag, "_data"},  32'(rsp_data),  32'({c.a, c.b}));
        check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flags(c)));
        check({tag, "_opco"},  32'(rsp_opco),  32'(c.opco));
    endtask

    // Consume n responses at the current rsp_ready setting, in queue order.
    task automatic collect(input int n, input int budget);
        int   got = 0;
        int   cyc = 0;
        cmd_t c;
        while (got < n && cyc < budget) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail_timeout("collect_unexpected_rsp");
                end else begin
                    c = exp_q.pop_front();
                    check_rsp("collect", c);
                    stat_ops_m++;
                    if (c.a == 8'd0) stat_zero_m++;
                end
                got++;
            end
            step();
            cyc++;
        end
        if (got < n) fail_timeout("collect");
    endtask

    task automatic wait_rsp_valid(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            step();
            n++;
        end
        if (!rsp_valid) fail_timeout("rsp_valid");
    endtask

`ifdef ALU_CMD_SEQUENCER_STATS_EN
    task automatic check_stats(input string tag);
        check({tag, "_stat_ops"},  32'(stat_ops),  32'(stat_ops_m));
        check({tag, "_stat_zero"}, 32'(stat_zero), 32'(stat_zero_m));
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   lat;

        vecs[0] = '{4'b0001, 8'hE2, 8'h8C, 16'hE28C, 5'b00001};
        vecs[1] = '{4'b0000, 8'h00, 8'h55, 16'h0055, 5'b00100};
        vecs[2] = '{4'b1010, 8'h12, 8'h34, 16'h1234, 5'b00000};
        vecs[3] = '{4'b1111, 8'hFF, 8'h00, 16'hFF00, 5'b00001};
        vecs[4] = '{4'b0011, 8'h00, 8'h00, 16'h0000, 5'b00101};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_opco = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        cmd_valid_1 = 1'b0; cmd_opco_1 = '0; cmd_a_1 = '0; cmd_b_1 = '0; rsp_ready_1 = 1'b0;
        step();
        step();

        // ---- reset state ----
        check("rst_alu_init",   32'(alu_init),   32'd0);
        check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        check("rst_rsp_data",   32'(rsp_data),   32'd0);
        rst = 1'b0;
        step();

        // ---- table: single commands, latency and result ----
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_cmd(vecs[i].opco, vecs[i].a, vecs[i].b);
            exp_q.delete();
            lat = 0;
            while (!rsp_valid && lat < 20) begin
                step();
                lat++;
            end
            check("tbl_latency",   32'(lat),       32'd3);
            check("tbl_rsp_data",  32'(rsp_data),  32'(vecs[i].exp_data));
            check("tbl_rsp_flags", 32'(rsp_flags), 32'(vecs[i].exp_flags));
            check("tbl_rsp_opco",  32'(rsp_opco),  32'(vecs[i].opco));
            check("tbl_alu_init",  32'(alu_init),  32'd1);
            step();
            check("tbl_rsp_clear", 32'(rsp_valid), 32'd0);
            stat_ops_m++;
            if (vecs[i].exp_flags[2]) stat_zero_m++;
`ifdef ALU_CMD_SEQUENCER_STATS_EN
            check_stats("tbl");
`endif
        end

        // ---- burst of 6 with back-pressure ----
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_cmd(4'(i), 8'hA0 + 8'(i), 8'h50 + 8'(i));
        end
        cmd_valid = 1'b1; cmd_opco = 4'd5; cmd_a = 8'hA5; cmd_b = 8'h55;
        step();
        step();
        wait_rsp_valid(20);
        check("burst_cmd_ready_low", 32'(cmd_ready),  32'd0);
        check("burst_fifo_full",     32'(fifo_count), 32'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid",  32'(rsp_valid),  32'd1);
            check("bp_rsp_data",   32'(rsp_data),   32'h0000A050);
            check("bp_rsp_opco",   32'(rsp_opco),   32'd0);
            check("bp_alu_ab",     32'({alu_a, alu_b}), 32'h0000A050);
            check("bp_fifo_count", 32'(fifo_count), 32'd4);
            step();
        end
        rsp_ready = 1'b1;
        fork
            send_cmd(4'd5, 8'hA5, 8'h55);
            collect(6, 300);
        join
        check("burst_drained_busy", 32'(busy), 32'd0);

        // ---- asynchronous reset during SETTLE with 3 queued ----
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_cmd(4'(i + 3), 8'h30 + 8'(i), 8'hC0 + 8'(i));
        end
        wait_rsp_valid(20);
        rsp_ready = 1'b1;
        collect(1, 20);
        rsp_ready = 1'b0;
        step();
        check("pre_rst_fifo_count", 32'(fifo_count), 32'd3);
        check("pre_rst_busy",       32'(busy),       32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_alu_init",   32'(alu_init),   32'd0);
        check("arst_alu_inputs", 32'({alu_opco, alu_a, alu_b}), 32'd0);
        check("arst_rsp",        32'({rsp_valid, rsp_opco, rsp_data, rsp_flags}), 32'd0);
        check("arst_fifo_count", 32'(fifo_count), 32'd0);
        check("arst_busy",       32'(busy),       32'd0);
        exp_q.delete();
        stat_ops_m  = 0;
        stat_zero_m = 0;
`ifdef ALU_CMD_SEQUENCER_STATS_EN
        check_stats("arst");
`endif
        step();
        rst = 1'b0;
        step();
        rsp_ready = 1'b1;
        send_cmd(4'd0, 8'h12, 8'h34);
        collect(1, 20);

        // ---- randomized traffic against the queue model ----
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_timeout("rnd_rsp_without_cmd");
                end else begin
                    check("rnd_alu_held", 32'({alu_opco, alu_a, alu_b}), 32'(exp_q[0]));
                    if (rsp_ready) begin
                        check_rsp("rnd", exp_q[0]);
                        stat_ops_m++;
                        if (exp_q[0].a == 8'd0) stat_zero_m++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{opco: cmd_opco, a: cmd_a, b: cmd_b});
            end
            step();
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_opco  = 4'($urandom);
            cmd_a     = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            cmd_b     = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        collect(exp_q.size(), 300);
        step();
        check("rnd_end_busy",       32'(busy),       32'd0);
        check("rnd_end_fifo_count", 32'(fifo_count), 32'd0);
`ifdef ALU_CMD_SEQUENCER_STATS_EN
        check_stats("rnd");
`endif

        // ---- SETTLE_CYCLES=1: throughput and simultaneous push/pop ----
        rsp_ready_1 = 1'b1;
        fork
            begin : pusher_1
                int n;
                for (int i = 0; i < 6; i++) begin
                    cmd_valid_1 = 1'b1;
                    cmd_opco_1  = 4'(i);
                    cmd_a_1     = 8'($urandom);
                    cmd_b_1     = 8'($urandom);
                    n = 0;
                    while (!cmd_ready_1 && n < 100) begin
                        step();
                        n++;
                    end
                    if (!cmd_ready_1) begin
                        fail_timeout("s1_accept");
                    end else begin
                        exp1_q.push_back('{opco: cmd_opco_1, a: cmd_a_1, b: cmd_b_1});
                        step();
                    end
                end
                cmd_valid_1 = 1'b0;
            end
            begin : collector_1
                int         got = 0;
                int         last_hs = -1;
                int         hs_cyc = -10;
                int         same_cnt_checks = 0;
                bit         both;
                logic [2:0] cnt_before;
                cmd_t       c;
                for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
                    // Edge right after a handshake is a pop edge when the FIFO holds data.
                    both       = (cyc == hs_cyc + 1) && cmd_valid_1 && cmd_ready_1 && (fifo_count_1 != 3'd0);
                    cnt_before = fifo_count_1;
                    if (rsp_valid_1 && rsp_ready_1) begin
                        if (exp1_q.size() == 0) begin
                            fail_timeout("s1_rsp_without_cmd");
                        end else begin
                            c = exp1_q.pop_front();
                            check("s1_rsp_data",  32'(rsp_data_1),  32'({c.a, c.b}));
                            check("s1_rsp_flags", 32'(rsp_flags_1), 32'(exp_flags(c)));
                            check("s1_rsp_opco",  32'(rsp_opco_1),  32'(c.opco));
                        end
                        if (last_hs >= 0) check("s1_spacing", 32'(cyc - last_hs), 32'd3);
                        last_hs = cyc;
                        hs_cyc  = cyc;
                        got++;
                    end
                    step();
                    if (both) begin
                        check("s1_push_pop_count", 32'(fifo_count_1), 32'(cnt_before));
                        same_cnt_checks++;
                    end
                end
                if (got < 6) fail_timeout("s1_collect");
                if (same_cnt_checks == 0) fail_timeout("s1_no_simultaneous_push_pop");
            end
        join
        step();
        check("s1_end_busy", 32'(busy_1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
